// File: rtl/fetch_pkg.sv
// Types and constants shared by the instruction-fetch stage.
// The PC_W/INS_W defaults used by fetch_unit and fetch_unit_if are taken from here.
package fetch_pkg;
    localparam int FETCH_PC_W  = 9;
    localparam int FETCH_INS_W = 32;
    localparam int PC_INC      = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]  pc;
        logic [FETCH_INS_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem req/ack on one side, redirect in, valid/ready instruction out.
// The master modport is the fetch unit; the slave modport is memory plus datapath.
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int PC_W  = FETCH_PC_W,
    parameter int INS_W = FETCH_INS_W
);
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_ack;
    logic [INS_W-1:0] imem_rdata;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             instr_valid;
    logic [INS_W-1:0] instr;
    logic [PC_W-1:0]  instr_pc;
    logic             instr_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a registered head; a push into an empty FIFO is visible one cycle later.
// Flush empties it and wins over push/pop; pop on empty is ignored; the caller never pushes when full.
module fetch_fifo #(
    parameter int W     = 41,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic          pop_ok;

    assign pop_ok = pop && (count != '0);
    assign rd_nxt = rd_ptr + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_nxt;
            count <= count + CW'(push) - CW'(pop_ok);
            // Head tracks whichever entry becomes oldest after this cycle's push/pop.
            if (push && ((count == '0) || (pop_ok && (count == CW'(1)))))
                head <= din;
            else if (pop_ok && (count > CW'(1)))
                head <= mem[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/fetch_unit.sv
// PC owner and imem requester; instr_valid rises 1 cycle after ack, 1 instr/cycle on zero-wait memory.
// Requests stop while the buffer would be full; redirect flushes and drops any in-flight response. Option: FETCH_STALL_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W       = FETCH_PC_W,
    parameter int              INS_W      = FETCH_INS_W,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic               clk,
    input  logic               reset,
    fetch_unit_if.master       bus
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]        fetch_stall_cnt
`endif
);
    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt, pc_plus, redir_pc, addr_nxt;
    logic            req_nxt;
    logic [CW-1:0]   count, count_after;
    logic            push, pop;
    fetch_entry_t    push_ent, head_ent;

    assign pc_plus     = pc + PC_W'(PC_INC);
    assign redir_pc    = {bus.redirect_pc[PC_W-1:2], 2'b00};
    assign push        = (state == S_WAIT) && bus.imem_ack && !bus.redirect_valid;
    assign pop         = bus.instr_valid && bus.instr_ready;
    assign count_after = count + CW'(push) - CW'(pop);
    assign push_ent    = '{pc: pc, instr: bus.imem_rdata};

    assign bus.instr_valid = (count != '0);
    assign bus.instr       = head_ent.instr;
    assign bus.instr_pc    = head_ent.pc;

    fetch_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (bus.redirect_valid),
        .push  (push),
        .din   (push_ent),
        .pop   (pop),
        .head  (head_ent),
        .count (count)
    );

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        req_nxt   = bus.imem_req;
        addr_nxt  = bus.imem_addr;
        unique case (state)
            S_IDLE: begin
                if (bus.redirect_valid) begin
                    pc_nxt = redir_pc;
                end else if (count < DEPTH_C) begin
                    state_nxt = S_WAIT;
                    req_nxt   = 1'b1;
                    addr_nxt  = pc;
                end
            end
            S_WAIT: begin
                if (bus.redirect_valid) begin
                    pc_nxt = redir_pc;
                    if (bus.imem_ack) begin
                        state_nxt = S_IDLE;
                        req_nxt   = 1'b0;
                    end else begin
                        // Old request stays on the bus until acked, then its data is thrown away.
                        state_nxt = S_DROP;
                    end
                end else if (bus.imem_ack) begin
                    pc_nxt = pc_plus;
                    if (count_after < DEPTH_C) begin
                        addr_nxt = pc_plus;
                    end else begin
                        state_nxt = S_IDLE;
                        req_nxt   = 1'b0;
                    end
                end
            end
            S_DROP: begin
                if (bus.redirect_valid)
                    pc_nxt = redir_pc;
                if (bus.imem_ack) begin
                    state_nxt = S_IDLE;
                    req_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= RESET_PC;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            bus.imem_req  <= req_nxt;
            bus.imem_addr <= addr_nxt;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            fetch_stall_cnt <= '0;
        else if (bus.redirect_valid)
            fetch_stall_cnt <= '0;
        else if (!bus.instr_valid && (state != S_DROP) && (fetch_stall_cnt != 32'hFFFF_FFFF))
            fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: zero-wait and slow memory, backpressure, redirect/drop, PC wrap, async reset.
module tb_fetch_unit;
    logic clk;
    logic reset;
    logic zw;
    logic man_ack;
    int   checks;
    int   errors;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus)
`ifdef FETCH_STALL_CNT_EN
        ,
        .fetch_stall_cnt (stall_cnt)
`endif
    );

    function automatic logic [31:0] mem_data(input logic [8:0] a);
        return 32'hC0DE_0000 ^ {23'd0, a};
    endfunction

    assign bus.imem_ack   = zw ? bus.imem_req : man_ack;
    assign bus.imem_rdata = mem_data(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        #2;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 9'h000) begin errors++; $display("FAIL rst_addr got %h exp 000", bus.imem_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.instr_valid); end
        checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", bus.instr); end
        checks++; if (bus.instr_pc !== 9'h000) begin errors++; $display("FAIL rst_instr_pc got %h exp 000", bus.instr_pc); end
    endtask

    task automatic test_zero_wait();
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h000) begin errors++; $display("FAIL zw_first_req got %b/%h exp 1/000", bus.imem_req, bus.imem_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL zw_not_yet_valid got %b exp 0", bus.instr_valid); end
`ifdef FETCH_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL stall_cnt1 got %0d exp 1", stall_cnt); end
`endif
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 9'h000) begin errors++; $display("FAIL zw_first_valid got %b/%h exp 1/000", bus.instr_valid, bus.instr_pc); end
        checks++; if (bus.instr !== 32'hC0DE_0000) begin errors++; $display("FAIL zw_first_instr got %h exp c0de0000", bus.instr); end
        checks++; if (bus.imem_addr !== 9'h004) begin errors++; $display("FAIL zw_addr1 got %h exp 004", bus.imem_addr); end
`ifdef FETCH_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL stall_cnt2 got %0d exp 2", stall_cnt); end
`endif
        for (int i = 1; i <= 3; i++) begin
            logic [8:0] epc;
            epc = 9'(4 * i);
            @(negedge clk);
            checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== epc) begin errors++; $display("FAIL zw_stream_pc got %b/%h exp 1/%h", bus.instr_valid, bus.instr_pc, epc); end
            checks++; if (bus.instr !== mem_data(epc)) begin errors++; $display("FAIL zw_stream_instr got %h exp %h", bus.instr, mem_data(epc)); end
            checks++; if (bus.imem_addr !== epc + 9'd4) begin errors++; $display("FAIL zw_stream_addr got %h exp %h", bus.imem_addr, epc + 9'd4); end
        end
`ifdef FETCH_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL stall_cnt_hold got %0d exp 2", stall_cnt); end
`endif
    endtask

    task automatic test_backpressure();
        bus.instr_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 9'h000;
        @(negedge clk); bus.redirect_valid = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_flush got %b/%b exp 0/0", bus.instr_valid, bus.imem_req); end
`ifdef FETCH_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stall_cnt_redirect got %0d exp 0", stall_cnt); end
`endif
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h000) begin errors++; $display("FAIL bp_req0 got %b/%h exp 1/000", bus.imem_req, bus.imem_addr); end
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h004) begin errors++; $display("FAIL bp_req4 got %b/%h exp 1/004", bus.imem_req, bus.imem_addr); end
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b0 || bus.instr_pc !== 9'h000) begin errors++; $display("FAIL bp_full got %b/%h exp 0/000", bus.imem_req, bus.instr_pc); end
        repeat (2) @(negedge clk);
        checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got %b/%b exp 0/1", bus.imem_req, bus.instr_valid); end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.instr_pc !== 9'h004 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_pop1 got %h/%b exp 004/0", bus.instr_pc, bus.imem_req); end
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h008) begin errors++; $display("FAIL bp_resume got %b/%h exp 1/008", bus.imem_req, bus.imem_addr); end
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 9'h008) begin errors++; $display("FAIL bp_third got %b/%h exp 1/008", bus.instr_valid, bus.instr_pc); end
    endtask

    task automatic test_latency();
        bus.instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        zw = 1'b0; man_ack = 1'b0; bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 9'h020;
        @(negedge clk); bus.redirect_valid = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL lat_idle got %b/%b exp 0/0", bus.instr_valid, bus.imem_req); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h020) begin errors++; $display("FAIL lat_stable got %b/%h exp 1/020", bus.imem_req, bus.imem_addr); end
        end
        man_ack = 1'b1;
        @(negedge clk); man_ack = 1'b0;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 9'h020 || bus.instr !== mem_data(9'h020)) begin errors++; $display("FAIL lat_push got %b/%h/%h exp 1/020/%h", bus.instr_valid, bus.instr_pc, bus.instr, mem_data(9'h020)); end
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 9'h024) begin errors++; $display("FAIL lat_single got %b/%h exp 0/024", bus.instr_valid, bus.imem_addr); end
    endtask

    task automatic test_redirect_drop();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 9'h008;
        @(negedge clk); bus.redirect_valid = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h024) begin errors++; $display("FAIL drop_hold_old got %b/%h exp 1/024", bus.imem_req, bus.imem_addr); end
        man_ack = 1'b1;
        @(negedge clk); man_ack = 1'b0;
        checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL drop_discard got %b/%b exp 0/0", bus.imem_req, bus.instr_valid); end
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h008) begin errors++; $display("FAIL drop_req8 got %b/%h exp 1/008", bus.imem_req, bus.imem_addr); end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 9'h040;
        @(negedge clk); bus.redirect_valid = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 9'h008) begin errors++; $display("FAIL drop_pending got %b/%h exp 0/008", bus.instr_valid, bus.imem_addr); end
        man_ack = 1'b1;
        @(negedge clk); man_ack = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL drop_8_dropped got %b exp 0", bus.instr_valid); end
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h040) begin errors++; $display("FAIL drop_next_addr got %b/%h exp 1/040", bus.imem_req, bus.imem_addr); end
        man_ack = 1'b1;
        @(negedge clk); man_ack = 1'b0;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 9'h040) begin errors++; $display("FAIL drop_first_pc got %b/%h exp 1/040", bus.instr_valid, bus.instr_pc); end
    endtask

    task automatic test_wrap();
        zw = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 9'h1F8;
        @(negedge clk); bus.redirect_valid = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL wrap_ack_redirect got %b/%b exp 0/0", bus.instr_valid, bus.imem_req); end
        @(negedge clk);
        checks++; if (bus.imem_addr !== 9'h1F8) begin errors++; $display("FAIL wrap_1f8 got %h exp 1f8", bus.imem_addr); end
        @(negedge clk);
        checks++; if (bus.imem_addr !== 9'h1FC || bus.instr_pc !== 9'h1F8) begin errors++; $display("FAIL wrap_1fc got %h/%h exp 1fc/1f8", bus.imem_addr, bus.instr_pc); end
        @(negedge clk);
        checks++; if (bus.imem_addr !== 9'h000 || bus.instr_pc !== 9'h1FC) begin errors++; $display("FAIL wrap_000 got %h/%h exp 000/1fc", bus.imem_addr, bus.instr_pc); end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 9'h043;
        @(negedge clk); bus.redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h040) begin errors++; $display("FAIL align_addr got %b/%h exp 1/040", bus.imem_req, bus.imem_addr); end
        @(negedge clk);
        checks++; if (bus.instr_pc !== 9'h040) begin errors++; $display("FAIL align_pc got %h exp 040", bus.instr_pc); end
    endtask

    task automatic test_reset_mid();
        zw = 1'b0; man_ack = 1'b0;
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL mid_pre_req got %b exp 1", bus.imem_req); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 9'h000) begin errors++; $display("FAIL mid_req_addr got %b/%h exp 0/000", bus.imem_req, bus.imem_addr); end
        checks++; if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0 || bus.instr_pc !== 9'h000) begin errors++; $display("FAIL mid_instr got %b/%h/%h exp 0/0/000", bus.instr_valid, bus.instr, bus.instr_pc); end
`ifdef FETCH_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL mid_stall_cnt got %0d exp 0", stall_cnt); end
`endif
        @(negedge clk); reset = 1'b1; zw = 1'b1;
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 9'h000) begin errors++; $display("FAIL mid_restart got %b/%h exp 1/000", bus.imem_req, bus.imem_addr); end
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 9'h000) begin errors++; $display("FAIL mid_restart_pc got %b/%h exp 1/000", bus.instr_valid, bus.instr_pc); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; zw = 1'b1; man_ack = 1'b0;
        bus.instr_ready = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_latency();
        test_redirect_drop();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle datapath.
- Owns the PC and issues requests to a variable-latency instruction memory using a req/ack handshake.
- Buffers returned instructions in a small FIFO and presents them to the datapath with valid/ready.
- Accepts branch/jump redirects, which flush in-flight work.

Parameters:
- PC_W, 9, PC and instruction-memory byte-address width.
- INS_W, 32, instruction width.
- FIFO_DEPTH, 2, instruction buffer entries; minimum 2, power of two.
- RESET_PC, 0, PC loaded at reset; must be 4-byte aligned.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held until ack.
- imem_addr  out  PC_W  fetch byte address; stable while imem_req=1.
- imem_ack  in  1  response strobe; may assert in the same cycle as imem_req.
- imem_rdata  in  INS_W  instruction; valid when imem_ack=1.
- redirect_valid  in  1  one-cycle PC redirect.
- redirect_pc  in  PC_W  redirect target; bits [1:0] ignored (forced 0).
- instr_valid  out  1  FIFO head valid.
- instr  out  INS_W  FIFO head instruction.
- instr_pc  out  PC_W  PC of FIFO head.
- instr_ready  in  1  datapath consumes head when instr_valid & instr_ready.
- fetch_stall_cnt  out  32  present only with FETCH_STALL_CNT_EN.

Behaviour:
- Reset values (asserted asynchronously, no clock needed):
  - imem_req=0, imem_addr=RESET_PC, pc=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=0.
  - FIFO count=0, state=S_IDLE.
- States:
  - S_IDLE: no request outstanding.
  - S_WAIT: request outstanding.
  - S_DROP: stale request outstanding; its response is discarded.
- S_IDLE -> S_WAIT when count < FIFO_DEPTH and no redirect. imem_req is registered and rises the next cycle, with imem_addr=pc.
- S_WAIT, imem_ack=1:
  - Push {pc, imem_rdata} into the FIFO; pc <= pc+4, modulo 2^PC_W (0x1FC wraps to 0x000).
  - If the FIFO has space after this push and any same-cycle pop, keep imem_req=1 with the new address and stay in S_WAIT. This gives back-to-back fetch at one instruction per cycle with a zero-wait memory.
  - Otherwise go to S_IDLE with imem_req=0.
- S_WAIT, imem_ack=0: hold imem_req and imem_addr.
- Redirect (highest priority; overrides push and pop in the same cycle):
  - Flush the FIFO (count=0, so instr_valid=0 the next cycle).
  - pc <= {redirect_pc[PC_W-1:2], 2'b00}.
  - If in S_WAIT without ack this cycle: go to S_DROP. imem_req stays high on the old address until ack, then that response is discarded and the unit goes to S_IDLE.
  - If ack arrives in the same cycle as the redirect: discard the response and go to S_IDLE.
  - Redirect while in S_DROP: update pc only.
- Output timing:
  - instr_valid = (count != 0); instr and instr_pc are registered FIFO head outputs.
  - Zero-wait memory: fetch latency is 1 cycle from the ack to instr_valid.
- FIFO rules:
  - Simultaneous push and pop: count unchanged.
  - Pop on empty: ignored.
  - Push never occurs when full; the request gating guarantees this.
- Reset asserted in mid-transaction abandons the outstanding request; the memory must tolerate req dropping.

Optional Feature:
- Macro FETCH_STALL_CNT_EN.
- Defined:
  - fetch_stall_cnt counts cycles with instr_valid=0 and state != S_DROP.
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset and by redirect.
- Undefined: the port and its counter logic are absent.

Decomposition:
- Package fetch_pkg holds:
  - enum fetch_state_t {S_IDLE, S_WAIT, S_DROP};
  - struct fetch_entry_t {pc[PC_W], instr[INS_W]};
  - localparam PC_INC=4.
- Sub-module fetch_fifo: synchronous FIFO with registered head, flush input, and count output.
- The FSM and PC logic stay in fetch_unit.

Test Plan:
- Release reset with zero-wait memory (ack=req) and instr_ready=1: imem_addr sequences 0x000,0x004,0x008; instr_valid first high one cycle after the first ack with instr_pc=0x000; one instruction per cycle thereafter.
- Hold instr_ready=0: FIFO fills to 2; imem_req drops with pc=0x008; raise ready; imem_req reasserts at 0x008 and instr_pc order is 0x000,0x004,0x008.
- Memory acks 3 cycles after req: imem_req and imem_addr stay stable for all 3 cycles; a single push follows.
- Redirect to 0x040 while the 0x008 request is outstanding: the 0x008 response is dropped; the next imem_addr is 0x040; the first delivered instr_pc is 0x040; instr_valid=0 the cycle after the redirect.
- Run pc to 0x1FC: next imem_addr=0x000; redirect_pc=0x043 fetches 0x040.
- Assert reset low mid-S_WAIT between clock edges: all outputs return to reset values immediately; with FETCH_STALL_CNT_EN, fetch_stall_cnt=0.
